// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one register stage per shift-amount bit
// (largest shift first), valid/ready on both sides with a global stall, tag carry and flush.
module pipe_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    mode_e              mode;
    logic               sign;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t stage_q [SHAMT_W];
  stage_t stage_d [SHAMT_W];
  stage_t src     [SHAMT_W];
  logic   advance;

  // SRA fills from the sign captured at entry, never from partially shifted data.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input mode_e m,
                                                  input logic sign,
                                                  input int amt);
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] r;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    case (m)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = (d >> amt) | (sign ? fill_mask : '0);
      MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      default:  r = d;
    endcase
    return r;
  endfunction

  assign advance = !stage_q[SHAMT_W-1].valid || out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
    src[0].valid = in_valid;
    src[0].data  = in_data;
    src[0].shamt = in_shamt;
    src[0].mode  = mode_e'(in_mode);
    src[0].sign  = in_data[WIDTH-1];
    src[0].tag   = in_tag;
    for (int k = 1; k < SHAMT_W; k++) begin
      src[k] = stage_q[k-1];
    end

    for (int k = 0; k < SHAMT_W; k++) begin
      stage_d[k] = stage_q[k];
    end

    if (flush) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_d[k] = '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (src[k].valid) begin
          stage_d[k] = src[k];
          if (src[k].shamt[SHAMT_W-1-k]) begin
            stage_d[k].data = shift_step(src[k].data, src[k].mode, src[k].sign,
                                         1 << (SHAMT_W - 1 - k));
          end
        end else begin
          // Bubbles carry a zero payload so the output reads 0 whenever it is not valid.
          stage_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: payload registers are reset along with the valids so out_data/out_tag read 0 straight after reset.
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage samples the pre-edge values.
      for (int k = 0; k < SHAMT_W; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = stage_q[SHAMT_W-1].valid;
  assign out_data  = stage_q[SHAMT_W-1].data;
  assign out_tag   = stage_q[SHAMT_W-1].tag;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter: an in-order queue model with per-op latency
// tracking checks every cycle, plus directed vectors with hand-computed results.
module tb_pipe_barrel_shifter;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  int n_tests   = 0;
  int n_fail    = 0;
  int delivered = 0;
  bit mon_en    = 1'b0;
  bit rand_rdy  = 1'b0;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            ticks;
  } exp_t;

  exp_t q[$];

  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_data = '0;
  logic [TW-1:0] stall_tag  = '0;

  pipe_barrel_shifter #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference result straight from the mode definitions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic signed [W-1:0] sd;
    logic [W-1:0]        r;
    sd = d;
    case (m)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = sd >>> s;
      default: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
    endcase
    return r;
  endfunction

  // Ops leave in order; an op is at the output once it has seen SW advancing edges.
  always @(negedge clock) begin : monitor
    logic exp_valid;
    exp_t e;
    if (mon_en) begin
      exp_valid = (q.size() > 0) && (q[0].ticks == SW);
      check("mon_out_valid", 64'(out_valid), 64'(exp_valid));
      if (out_valid) begin
        if (q.size() > 0) begin
          check("mon_out_data", 64'(out_data), 64'(q[0].data));
          check("mon_out_tag", 64'(out_tag), 64'(q[0].tag));
        end
      end else begin
        check("mon_idle_data", 64'(out_data), 64'd0);
        check("mon_idle_tag", 64'(out_tag), 64'd0);
      end
      check("mon_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stall_prev && out_valid) begin
        check("mon_stall_data", 64'(out_data), 64'(stall_data));
        check("mon_stall_tag", 64'(out_tag), 64'(stall_tag));
      end

      if (reset) begin
        q.delete();
      end else if (!out_valid || out_ready) begin
        if (out_valid && q.size() > 0) begin
          void'(q.pop_front());
          delivered++;
        end
        for (int i = 0; i < q.size(); i++) begin
          q[i].ticks = q[i].ticks + 1;
        end
        if (flush) begin
          q.delete();
        end else if (in_valid) begin
          e.data  = ref_shift(in_data, int'(in_shamt), in_mode);
          e.tag   = in_tag;
          e.ticks = 1;
          q.push_back(e);
        end
      end else if (flush) begin
        q.delete();
      end

      stall_prev = out_valid && !out_ready && !reset && !flush;
      stall_data = out_data;
      stall_tag  = out_tag;
    end
  end

  task automatic send(input logic [W-1:0] d, input int s, input logic [1:0] m, input logic [TW-1:0] t);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SW'(s);
    in_mode  = m;
    in_tag   = t;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 1000) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = in_ready && !flush && !reset;
      @(posedge clock);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: op tag %0d not accepted", t);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] d);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(d));
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 60) begin
      @(posedge clock);
      #1;
      guard++;
    end
    check({name, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int base;
    logic [W-1:0]  sd;
    logic [TW-1:0] st;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // SRA of the most negative value by 31: all ones, 5 cycles after acceptance.
    send(32'h8000_0000, 31, 2'b10, 5'd3);
    wait_valid(n);
    check("sra_latency", 64'(n + 1), 64'd5);
    check("sra_data", 64'(out_data), 64'hFFFF_FFFF);
    check("sra_tag", 64'(out_tag), 64'd3);
    drain("sra");

    // Mode sweep, back to back; results on four consecutive cycles.
    send(32'h0000_0001, 31, 2'b00, 5'd1);
    send(32'h8000_0000, 16, 2'b01, 5'd2);
    send(32'h1234_5678, 4, 2'b11, 5'd4);
    send(32'h7000_0000, 4, 2'b10, 5'd5);
    wait_valid(n);
    expect_out("sweep_sll", 32'h8000_0000);
    expect_out("sweep_srl", 32'h0000_8000);
    expect_out("sweep_ror", 32'h8123_4567);
    expect_out("sweep_sra", 32'h0700_0000);
    drain("sweep");

    // Shift by zero is the identity in every mode.
    for (int m = 0; m < 4; m++) send(32'hDEAD_BEEF, 0, 2'(m), 5'(m + 10));
    wait_valid(n);
    for (int m = 0; m < 4; m++) expect_out($sformatf("zero_mode%0d", m), 32'hDEAD_BEEF);
    drain("zero");

    // Random ops with random backpressure and gaps, checked by the monitor model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clock);
        #1;
      end
      send($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end
    rand_rdy = 1'b0;
    drain("random");

    // Backpressure: stall 3 cycles once the first of 8 results shows up.
    base = delivered;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h0101_0101 * (i + 1), i + 1, 2'(i % 4), 5'(16 + i));
    check("bp_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_0006;
    in_shamt  = 5'd6;
    in_mode   = 2'b01;
    in_tag    = 5'd21;
    #1;
    sd = out_data;
    st = out_tag;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_data", 64'(out_data), 64'(sd));
      check("bp_hold_tag", 64'(out_tag), 64'(st));
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send(32'hCAFE_0006, 6, 2'b01, 5'd21);
    send(32'hCAFE_0007, 7, 2'b10, 5'd22);
    send(32'hCAFE_0008, 8, 2'b11, 5'd23);
    drain("bp");
    check("bp_delivered", 64'(delivered - base), 64'd8);

    // Flush with 3 ops in flight and a 4th offered on the flush cycle.
    base = delivered;
    send(32'h1111_1111, 1, 2'b00, 5'd1);
    send(32'h2222_2222, 2, 2'b01, 5'd2);
    send(32'h3333_3333, 3, 2'b11, 5'd3);
    in_valid = 1'b1;
    in_data  = 32'h4444_4444;
    in_shamt = 5'd4;
    in_mode  = 2'b10;
    in_tag   = 5'd4;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      check("flush_quiet", 64'(out_valid), 64'd0);
    end
    check("flush_none_delivered", 64'(delivered - base), 64'd0);
    send(32'hF000_0000, 4, 2'b01, 5'd9);
    wait_valid(n);
    check("flush_new_latency", 64'(n + 1), 64'd5);
    check("flush_new_data", 64'(out_data), 64'h0F00_0000);
    check("flush_new_tag", 64'(out_tag), 64'd9);
    @(posedge clock);
    #1;
    check("flush_delivered", 64'(delivered - base), 64'd1);

    // Reset with a full, stalled pipeline.
    base = delivered;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'hA5A5_0000 + 32'(i), i, 2'(i % 4), 5'(24 + i));
    check("full_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_tag", 64'(out_tag), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_000F, 1, 2'b11, 5'd30);
    wait_valid(n);
    check("post_rst_latency", 64'(n + 1), 64'd5);
    check("post_rst_data", 64'(out_data), 64'h8000_0007);
    check("post_rst_tag", 64'(out_tag), 64'd30);
    drain("post_rst");
    check("post_rst_delivered", 64'(delivered - base), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
